// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared types and constants for the hazard scoreboard
//
// Purpose: divider FSM encoding, default register address width, shadow-slot
// field counts and the width of the per-register pending vector.
// Ports: none (package).

package hazard_scoreboard_pkg;

  // Default GPR address width (32 architectural registers).
  localparam int ADDR_W_DEF = 5;

  // One pending bit per architectural register.
  localparam int PENDING_W = 32;

  // Single-bit control fields carried by each shadow slot: valid, wr, load.
  localparam int SLOT_CTRL_W = 3;

  // Slot width for the default address width.
  localparam int SLOT_W_DEF = SLOT_CTRL_W + ADDR_W_DEF;

  // Divider occupancy FSM.
  typedef enum logic {
    RUN      = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_t;

endpackage

// File: rtl/hazard_scoreboard_slot_match.sv
// rtl/hazard_scoreboard_slot_match.sv - compare one shadow slot against one ID source operand
//
// Purpose: reports that an in-flight register write targets the register an
// ID-stage instruction needs. Writes to register 0 never match.
// Ports:
//   slot_valid  in  1       slot holds a real instruction
//   slot_wr     in  1       slot instruction writes a GPR
//   slot_addr   in  ADDR_W  slot destination register
//   src_addr    in  ADDR_W  ID-stage source register
//   src_used    in  1       ID instruction actually consumes src_addr
//   hit         out 1       slot will write the register the operand needs

module hazard_slot_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              slot_valid,
  input  logic              slot_wr,
  input  logic [ADDR_W-1:0] slot_addr,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic              src_used,
  output logic              hit
);

  logic nonzero_dest;

  // $0 is hardwired; a write to it is never a dependency.
  assign nonzero_dest = (slot_addr != '0);

  assign hit = slot_valid & slot_wr & nonzero_dest & src_used & (slot_addr == src_addr);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight write tracking and stall generation beside the ID stage
//
// Purpose: shadows the instructions in EX and MEM, tracks divider occupancy and
// raises a stall when forwarding cannot supply an ID-stage operand (load-use,
// branch-on-load, HI/LO access while the divider is busy).
// Ports:
//   clk           in  1         pipeline clock, rising edge
//   rstn          in  1         asynchronous active-low reset
//   RegSource_ID  in  ADDR_W    rs of instruction in ID
//   RegTarget_ID  in  ADDR_W    rt of instruction in ID
//   UsesRs_ID     in  1         ID instruction reads rs in EX
//   UsesRt_ID     in  1         ID instruction reads rt in EX
//   BranchUse_ID  in  1         ID instruction compares/jumps on rs/rt in ID
//   ValidID       in  1         ID holds a real instruction
//   RegWrite_ID   in  1         ID instruction writes a GPR
//   WriteAddr_ID  in  ADDR_W    its destination
//   MemRead_ID    in  1         ID instruction is a load
//   DivStart_ID   in  1         ID instruction is div/divu
//   HiLoRead_ID   in  1         ID instruction is mfhi/mflo
//   Flush         in  1         kill all in-flight shadow state
//   StallPC       out 1         hold PC
//   StallIFID     out 1         hold IF/ID register
//   BubbleIDEX    out 1         load nop into ID/EX
//   DivBusy       out 1         divider occupied
//   Pending       out 32        bit r set while a write to r is in EX or MEM

module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DIV_LATENCY = 8,
  parameter int CNT_W       = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [ADDR_W-1:0]    RegSource_ID,
  input  logic [ADDR_W-1:0]    RegTarget_ID,
  input  logic                 UsesRs_ID,
  input  logic                 UsesRt_ID,
  input  logic                 BranchUse_ID,
  input  logic                 ValidID,
  input  logic                 RegWrite_ID,
  input  logic [ADDR_W-1:0]    WriteAddr_ID,
  input  logic                 MemRead_ID,
  input  logic                 DivStart_ID,
  input  logic                 HiLoRead_ID,
  input  logic                 Flush,
  output logic                 StallPC,
  output logic                 StallIFID,
  output logic                 BubbleIDEX,
  output logic                 DivBusy,
  output logic [PENDING_W-1:0] Pending
);

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic              load;
  } slot_t;

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);

  slot_t              ex_slot;
  slot_t              mem_slot;
  slot_t              id_slot;
  div_state_t         state;
  logic [CNT_W-1:0]   div_cnt;

  logic ex_rs_hit, ex_rt_hit;
  logic mem_rs_hit, mem_rt_hit;
  logic load_use, branch_on_load, div_hazard;
  logic stall;

  // EX operands are needed by ALU users and by branches resolved in ID.
  hazard_slot_match #(.ADDR_W(ADDR_W)) u_ex_rs (
    .slot_valid (ex_slot.valid),
    .slot_wr    (ex_slot.wr),
    .slot_addr  (ex_slot.addr),
    .src_addr   (RegSource_ID),
    .src_used   (UsesRs_ID | BranchUse_ID),
    .hit        (ex_rs_hit)
  );

  hazard_slot_match #(.ADDR_W(ADDR_W)) u_ex_rt (
    .slot_valid (ex_slot.valid),
    .slot_wr    (ex_slot.wr),
    .slot_addr  (ex_slot.addr),
    .src_addr   (RegTarget_ID),
    .src_used   (UsesRt_ID | BranchUse_ID),
    .hit        (ex_rt_hit)
  );

  // A load in MEM can still be forwarded into EX, but not into a branch
  // comparator that resolves in ID.
  hazard_slot_match #(.ADDR_W(ADDR_W)) u_mem_rs (
    .slot_valid (mem_slot.valid),
    .slot_wr    (mem_slot.wr),
    .slot_addr  (mem_slot.addr),
    .src_addr   (RegSource_ID),
    .src_used   (BranchUse_ID),
    .hit        (mem_rs_hit)
  );

  hazard_slot_match #(.ADDR_W(ADDR_W)) u_mem_rt (
    .slot_valid (mem_slot.valid),
    .slot_wr    (mem_slot.wr),
    .slot_addr  (mem_slot.addr),
    .src_addr   (RegTarget_ID),
    .src_used   (BranchUse_ID),
    .hit        (mem_rt_hit)
  );

  // Only load results cause stalls; ALU results are always forwardable.
  assign load_use       = ex_slot.load & (ex_rs_hit | ex_rt_hit);
  assign branch_on_load = mem_slot.load & (mem_rs_hit | mem_rt_hit);
  assign div_hazard     = (state == DIV_BUSY) & (HiLoRead_ID | DivStart_ID);

  assign stall = ValidID & (load_use | branch_on_load | div_hazard);

  assign StallPC    = stall;
  assign StallIFID  = stall;
  assign BubbleIDEX = stall;
  assign DivBusy    = (state == DIV_BUSY);

  // A stalled ID instruction enters EX as a bubble.
  always_comb begin
    id_slot       = '0;
    id_slot.valid = ValidID & ~stall;
    id_slot.wr    = RegWrite_ID;
    id_slot.addr  = WriteAddr_ID;
    id_slot.load  = MemRead_ID;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_slot  <= '0;
      mem_slot <= '0;
    end else if (Flush) begin
      ex_slot  <= '0;
      mem_slot <= '0;
    end else begin
      ex_slot  <= id_slot;
      mem_slot <= ex_slot;
    end
  end

  // Divider occupancy: counter runs DIV_LATENCY-1 down to 0, one busy cycle
  // per count, so HI/LO readers issue the cycle after the counter hits 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= RUN;
      div_cnt <= '0;
    end else if (Flush) begin
      state   <= RUN;
      div_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (DivStart_ID & ValidID & ~stall) begin
            state   <= DIV_BUSY;
            div_cnt <= DIV_LOAD;
          end
        end
        DIV_BUSY: begin
          if (div_cnt == '0) begin
            state <= RUN;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        default: begin
          state   <= RUN;
          div_cnt <= '0;
        end
      endcase
    end
  end

  // Writes to $0 are discarded by the register file and never pend.
  always_comb begin
    Pending = '0;
    if (mem_slot.valid & mem_slot.wr & (mem_slot.addr != '0)) begin
      Pending[mem_slot.addr] = 1'b1;
    end
    if (ex_slot.valid & ex_slot.wr & (ex_slot.addr != '0)) begin
      Pending[ex_slot.addr] = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard

module tb_hazard_scoreboard;

  logic        clk;
  logic        rstn;
  logic [4:0]  RegSource_ID, RegTarget_ID, WriteAddr_ID;
  logic        UsesRs_ID, UsesRt_ID, BranchUse_ID, ValidID, RegWrite_ID;
  logic        MemRead_ID, DivStart_ID, HiLoRead_ID, Flush;
  logic        StallPC, StallIFID, BubbleIDEX, DivBusy;
  logic [31:0] Pending;

  int tests  = 0;
  int failed = 0;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs, urt, br, wr;
    logic [4:0] wa;
    logic       mr, ds, hl, fl;
  } stim_t;

  typedef struct {
    string       name;
    logic        stall;
    logic        busy;
    logic [31:0] pend;
  } exp_t;

  exp_t exp_q[$];

  hazard_scoreboard #(.ADDR_W(5), .DIV_LATENCY(8), .CNT_W(4)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .RegSource_ID (RegSource_ID),
    .RegTarget_ID (RegTarget_ID),
    .UsesRs_ID    (UsesRs_ID),
    .UsesRt_ID    (UsesRt_ID),
    .BranchUse_ID (BranchUse_ID),
    .ValidID      (ValidID),
    .RegWrite_ID  (RegWrite_ID),
    .WriteAddr_ID (WriteAddr_ID),
    .MemRead_ID   (MemRead_ID),
    .DivStart_ID  (DivStart_ID),
    .HiLoRead_ID  (HiLoRead_ID),
    .Flush        (Flush),
    .StallPC      (StallPC),
    .StallIFID    (StallIFID),
    .BubbleIDEX   (BubbleIDEX),
    .DivBusy      (DivBusy),
    .Pending      (Pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t op_nop();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t op_lw(input logic [4:0] wa);
    stim_t s;
    s = '0;
    s.v = 1'b1; s.rs = 5'd29; s.urs = 1'b1; s.wr = 1'b1; s.wa = wa; s.mr = 1'b1;
    return s;
  endfunction

  function automatic stim_t op_alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wa);
    stim_t s;
    s = '0;
    s.v = 1'b1; s.rs = rs; s.rt = rt; s.urs = 1'b1; s.urt = 1'b1; s.wr = 1'b1; s.wa = wa;
    return s;
  endfunction

  function automatic stim_t op_br(input logic [4:0] rs, input logic [4:0] rt);
    stim_t s;
    s = '0;
    s.v = 1'b1; s.rs = rs; s.rt = rt; s.br = 1'b1;
    return s;
  endfunction

  function automatic stim_t op_div(input logic [4:0] rs, input logic [4:0] rt);
    stim_t s;
    s = '0;
    s.v = 1'b1; s.rs = rs; s.rt = rt; s.urs = 1'b1; s.urt = 1'b1; s.ds = 1'b1;
    return s;
  endfunction

  function automatic stim_t op_mf(input logic [4:0] wa);
    stim_t s;
    s = '0;
    s.v = 1'b1; s.hl = 1'b1; s.wr = 1'b1; s.wa = wa;
    return s;
  endfunction

  function automatic stim_t flushed(input stim_t s_in);
    stim_t s;
    s = s_in;
    s.fl = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] pb(input int r);
    return 32'd1 << r;
  endfunction

  function automatic exp_t mk_exp(input string n, input logic s, input logic b, input logic [31:0] p);
    exp_t e;
    e.name = n; e.stall = s; e.busy = b; e.pend = p;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    ValidID      = s.v;
    RegSource_ID = s.rs;
    RegTarget_ID = s.rt;
    UsesRs_ID    = s.urs;
    UsesRt_ID    = s.urt;
    BranchUse_ID = s.br;
    RegWrite_ID  = s.wr;
    WriteAddr_ID = s.wa;
    MemRead_ID   = s.mr;
    DivStart_ID  = s.ds;
    HiLoRead_ID  = s.hl;
    Flush        = s.fl;
  endtask

  task automatic test_reset();
    exp_t e;
    rstn = 1'b0;
    drive(op_br(5'd3, 5'd3));
    exp_q.push_back(mk_exp("reset_held", 1'b0, 1'b0, 32'd0));
    @(negedge clk);
    e = exp_q.pop_front();
    tests++;
    if (StallPC !== e.stall || StallIFID !== e.stall || BubbleIDEX !== e.stall || DivBusy !== e.busy || Pending !== e.pend) begin
      failed++;
      $display("FAIL %s: stall=%b%b%b busy=%b pending=%h, expected stall=%b busy=%b pending=%h",
               e.name, StallPC, StallIFID, BubbleIDEX, DivBusy, Pending, e.stall, e.busy, e.pend);
    end
    @(negedge clk);
    rstn = 1'b1;
    drive(op_nop());
    exp_q.push_back(mk_exp("reset_released", 1'b0, 1'b0, 32'd0));
    @(negedge clk);
    e = exp_q.pop_front();
    tests++;
    if (StallPC !== e.stall || StallIFID !== e.stall || BubbleIDEX !== e.stall || DivBusy !== e.busy || Pending !== e.pend) begin
      failed++;
      $display("FAIL %s: stall=%b%b%b busy=%b pending=%h, expected stall=%b busy=%b pending=%h",
               e.name, StallPC, StallIFID, BubbleIDEX, DivBusy, Pending, e.stall, e.busy, e.pend);
    end
  endtask

  task automatic test_load_use();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back(op_lw(5'd3));           ex.push_back(mk_exp("lu_issue_lw",   1'b0, 1'b0, 32'd0));
    st.push_back(op_alu(5'd3, 5'd4, 5'd5)); ex.push_back(mk_exp("lu_stall",   1'b1, 1'b0, pb(3)));
    st.push_back(op_alu(5'd3, 5'd4, 5'd5)); ex.push_back(mk_exp("lu_release", 1'b0, 1'b0, pb(3)));
    st.push_back(op_nop());              ex.push_back(mk_exp("lu_add_in_ex",  1'b0, 1'b0, pb(5)));
    st.push_back(op_nop());              ex.push_back(mk_exp("lu_add_in_mem", 1'b0, 1'b0, pb(5)));
    st.push_back(op_nop());              ex.push_back(mk_exp("lu_drained",    1'b0, 1'b0, 32'd0));
    for (int i = 0; i < st.size(); i++) begin
      @(posedge clk); #1;
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (StallPC !== e.stall || StallIFID !== e.stall || BubbleIDEX !== e.stall || DivBusy !== e.busy || Pending !== e.pend) begin
        failed++;
        $display("FAIL %s: stall=%b%b%b busy=%b pending=%h, expected stall=%b busy=%b pending=%h",
                 e.name, StallPC, StallIFID, BubbleIDEX, DivBusy, Pending, e.stall, e.busy, e.pend);
      end
    end
  endtask

  task automatic test_branch_on_load();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back(op_lw(5'd3));             ex.push_back(mk_exp("bl_issue_lw",    1'b0, 1'b0, 32'd0));
    st.push_back(op_br(5'd3, 5'd7));       ex.push_back(mk_exp("bl_stall_ex",    1'b1, 1'b0, pb(3)));
    st.push_back(op_br(5'd3, 5'd7));       ex.push_back(mk_exp("bl_stall_mem",   1'b1, 1'b0, pb(3)));
    st.push_back(op_br(5'd3, 5'd7));       ex.push_back(mk_exp("bl_release",     1'b0, 1'b0, 32'd0));
    st.push_back(op_nop());                ex.push_back(mk_exp("bl_idle",        1'b0, 1'b0, 32'd0));
    st.push_back(op_alu(5'd1, 5'd2, 5'd3)); ex.push_back(mk_exp("ba_issue_add",  1'b0, 1'b0, 32'd0));
    st.push_back(op_br(5'd3, 5'd7));       ex.push_back(mk_exp("ba_alu_ex_nostall",  1'b0, 1'b0, pb(3)));
    st.push_back(op_br(5'd7, 5'd3));       ex.push_back(mk_exp("ba_alu_mem_nostall", 1'b0, 1'b0, pb(3)));
    st.push_back(op_nop());                ex.push_back(mk_exp("ba_drained",     1'b0, 1'b0, 32'd0));
    for (int i = 0; i < st.size(); i++) begin
      @(posedge clk); #1;
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (StallPC !== e.stall || StallIFID !== e.stall || BubbleIDEX !== e.stall || DivBusy !== e.busy || Pending !== e.pend) begin
        failed++;
        $display("FAIL %s: stall=%b%b%b busy=%b pending=%h, expected stall=%b busy=%b pending=%h",
                 e.name, StallPC, StallIFID, BubbleIDEX, DivBusy, Pending, e.stall, e.busy, e.pend);
      end
    end
  endtask

  task automatic test_zero_reg();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back(op_lw(5'd0));             ex.push_back(mk_exp("z_issue_lw0",  1'b0, 1'b0, 32'd0));
    st.push_back(op_br(5'd0, 5'd0));       ex.push_back(mk_exp("z_ex_nostall", 1'b0, 1'b0, 32'd0));
    st.push_back(op_br(5'd0, 5'd0));       ex.push_back(mk_exp("z_mem_nostall", 1'b0, 1'b0, 32'd0));
    st.push_back(op_alu(5'd0, 5'd0, 5'd0)); ex.push_back(mk_exp("z_alu_wr0",   1'b0, 1'b0, 32'd0));
    st.push_back(op_alu(5'd0, 5'd0, 5'd9)); ex.push_back(mk_exp("z_no_pend0",  1'b0, 1'b0, 32'd0));
    st.push_back(op_nop());                ex.push_back(mk_exp("z_pend9",      1'b0, 1'b0, pb(9)));
    for (int i = 0; i < st.size(); i++) begin
      @(posedge clk); #1;
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (StallPC !== e.stall || StallIFID !== e.stall || BubbleIDEX !== e.stall || DivBusy !== e.busy || Pending !== e.pend) begin
        failed++;
        $display("FAIL %s: stall=%b%b%b busy=%b pending=%h, expected stall=%b busy=%b pending=%h",
                 e.name, StallPC, StallIFID, BubbleIDEX, DivBusy, Pending, e.stall, e.busy, e.pend);
      end
    end
  endtask

  task automatic test_div();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back(op_nop());          ex.push_back(mk_exp("div_pre",   1'b0, 1'b0, pb(9)));
    st.push_back(op_div(5'd1, 5'd2)); ex.push_back(mk_exp("div_issue", 1'b0, 1'b0, 32'd0));
    for (int k = 0; k < 8; k++) begin
      st.push_back(op_mf(5'd8));
      ex.push_back(mk_exp($sformatf("div_mflo_stall%0d", k), 1'b1, 1'b1, 32'd0));
    end
    st.push_back(op_mf(5'd8));       ex.push_back(mk_exp("div_mflo_issue", 1'b0, 1'b0, 32'd0));
    st.push_back(op_nop());          ex.push_back(mk_exp("div_mflo_ex",    1'b0, 1'b0, pb(8)));
    st.push_back(op_nop());          ex.push_back(mk_exp("div_mflo_mem",   1'b0, 1'b0, pb(8)));
    st.push_back(op_nop());          ex.push_back(mk_exp("div_drained",    1'b0, 1'b0, 32'd0));
    for (int i = 0; i < st.size(); i++) begin
      @(posedge clk); #1;
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (StallPC !== e.stall || StallIFID !== e.stall || BubbleIDEX !== e.stall || DivBusy !== e.busy || Pending !== e.pend) begin
        failed++;
        $display("FAIL %s: stall=%b%b%b busy=%b pending=%h, expected stall=%b busy=%b pending=%h",
                 e.name, StallPC, StallIFID, BubbleIDEX, DivBusy, Pending, e.stall, e.busy, e.pend);
      end
    end
  endtask

  task automatic test_flush();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back(op_div(5'd1, 5'd2));                ex.push_back(mk_exp("fl_div_issue",   1'b0, 1'b0, 32'd0));
    st.push_back(op_lw(5'd4));                       ex.push_back(mk_exp("fl_lw_in_busy",  1'b0, 1'b1, 32'd0));
    st.push_back(flushed(op_alu(5'd4, 5'd6, 5'd7))); ex.push_back(mk_exp("fl_flush_cycle", 1'b1, 1'b1, pb(4)));
    st.push_back(op_nop());                          ex.push_back(mk_exp("fl_all_clear",   1'b0, 1'b0, 32'd0));
    st.push_back(flushed(op_div(5'd1, 5'd2)));       ex.push_back(mk_exp("fl_div_and_flush", 1'b0, 1'b0, 32'd0));
    st.push_back(op_nop());                          ex.push_back(mk_exp("fl_div_killed",  1'b0, 1'b0, 32'd0));
    st.push_back(flushed(op_lw(5'd9)));              ex.push_back(mk_exp("fl_lw_and_flush", 1'b0, 1'b0, 32'd0));
    st.push_back(op_nop());                          ex.push_back(mk_exp("fl_lw_killed",   1'b0, 1'b0, 32'd0));
    for (int i = 0; i < st.size(); i++) begin
      @(posedge clk); #1;
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (StallPC !== e.stall || StallIFID !== e.stall || BubbleIDEX !== e.stall || DivBusy !== e.busy || Pending !== e.pend) begin
        failed++;
        $display("FAIL %s: stall=%b%b%b busy=%b pending=%h, expected stall=%b busy=%b pending=%h",
                 e.name, StallPC, StallIFID, BubbleIDEX, DivBusy, Pending, e.stall, e.busy, e.pend);
      end
    end
  endtask

  task automatic test_async_reset();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back(op_div(5'd1, 5'd2)); ex.push_back(mk_exp("ar_div_issue", 1'b0, 1'b0, 32'd0));
    st.push_back(op_lw(5'd6));        ex.push_back(mk_exp("ar_lw_issue",  1'b0, 1'b1, 32'd0));
    st.push_back(op_mf(5'd8));        ex.push_back(mk_exp("ar_mflo_stall", 1'b1, 1'b1, pb(6)));
    for (int i = 0; i < st.size(); i++) begin
      @(posedge clk); #1;
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (StallPC !== e.stall || StallIFID !== e.stall || BubbleIDEX !== e.stall || DivBusy !== e.busy || Pending !== e.pend) begin
        failed++;
        $display("FAIL %s: stall=%b%b%b busy=%b pending=%h, expected stall=%b busy=%b pending=%h",
                 e.name, StallPC, StallIFID, BubbleIDEX, DivBusy, Pending, e.stall, e.busy, e.pend);
      end
    end
    // Mid-cycle: assert reset between edges and look before any clock edge.
    @(posedge clk); #1;
    drive(op_mf(5'd8));
    #1;
    exp_q.push_back(mk_exp("ar_before_reset", 1'b1, 1'b1, pb(6)));
    e = exp_q.pop_front();
    tests++;
    if (StallPC !== e.stall || StallIFID !== e.stall || BubbleIDEX !== e.stall || DivBusy !== e.busy || Pending !== e.pend) begin
      failed++;
      $display("FAIL %s: stall=%b%b%b busy=%b pending=%h, expected stall=%b busy=%b pending=%h",
               e.name, StallPC, StallIFID, BubbleIDEX, DivBusy, Pending, e.stall, e.busy, e.pend);
    end
    rstn = 1'b0;
    #1;
    exp_q.push_back(mk_exp("ar_async_clear", 1'b0, 1'b0, 32'd0));
    e = exp_q.pop_front();
    tests++;
    if (StallPC !== e.stall || StallIFID !== e.stall || BubbleIDEX !== e.stall || DivBusy !== e.busy || Pending !== e.pend) begin
      failed++;
      $display("FAIL %s: stall=%b%b%b busy=%b pending=%h, expected stall=%b busy=%b pending=%h",
               e.name, StallPC, StallIFID, BubbleIDEX, DivBusy, Pending, e.stall, e.busy, e.pend);
    end
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    drive(op_nop());
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back(op_div(5'd1, 5'd2)); ex.push_back(mk_exp("bb_div1_issue", 1'b0, 1'b0, 32'd0));
    for (int k = 0; k < 8; k++) begin
      st.push_back(op_div(5'd3, 5'd4));
      ex.push_back(mk_exp($sformatf("bb_div2_stall%0d", k), 1'b1, 1'b1, 32'd0));
    end
    st.push_back(op_div(5'd3, 5'd4)); ex.push_back(mk_exp("bb_div2_issue", 1'b0, 1'b0, 32'd0));
    st.push_back(op_nop());           ex.push_back(mk_exp("bb_div2_busy",  1'b0, 1'b1, 32'd0));
    st.push_back(flushed(op_nop()));  ex.push_back(mk_exp("bb_flush_idle", 1'b0, 1'b1, 32'd0));
    st.push_back(op_nop());           ex.push_back(mk_exp("bb_after_flush", 1'b0, 1'b0, 32'd0));
    for (int i = 0; i < st.size(); i++) begin
      @(posedge clk); #1;
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (StallPC !== e.stall || StallIFID !== e.stall || BubbleIDEX !== e.stall || DivBusy !== e.busy || Pending !== e.pend) begin
        failed++;
        $display("FAIL %s: stall=%b%b%b busy=%b pending=%h, expected stall=%b busy=%b pending=%h",
                 e.name, StallPC, StallIFID, BubbleIDEX, DivBusy, Pending, e.stall, e.busy, e.pend);
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    drive(op_nop());
    test_reset();
    test_load_use();
    test_branch_on_load();
    test_zero_reg();
    test_div();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
